// File: rtl/miner_job_scheduler_if.sv
// Job, core-array and solution signals between the scheduler and its environment.
// master: the scheduler side; slave: register file plus core array.
interface miner_job_scheduler_if #(
  parameter int unsigned NUM_CORES = 4
);
  logic                      job_valid;
  logic                      job_ready;
  logic [63:0]               job_start_nonce;
  logic                      stop;
  logic [NUM_CORES-1:0]      core_run;
  logic [64*NUM_CORES-1:0]   core_start_nonce;
  logic [NUM_CORES-1:0]      core_found;
  logic [64*NUM_CORES-1:0]   core_solution;
  logic [NUM_CORES-1:0]      core_ack;
  logic                      soln_valid;
  logic                      soln_ready;
  logic [63:0]               soln_nonce;
  logic [3:0]                soln_core;
  logic                      busy;
  logic                      irq;
  logic                      irq_clr;
  logic                      timed_out;

  modport master (
    input  job_valid, job_start_nonce, stop, core_found, core_solution, soln_ready, irq_clr,
    output job_ready, core_run, core_start_nonce, core_ack, soln_valid, soln_nonce, soln_core,
           busy, irq, timed_out
  );

  modport slave (
    output job_valid, job_start_nonce, stop, core_found, core_solution, soln_ready, irq_clr,
    input  job_ready, core_run, core_start_nonce, core_ack, soln_valid, soln_nonce, soln_core,
           busy, irq, timed_out
  );
endinterface

// File: rtl/miner_job_scheduler.sv
// Splits a job's nonce space across NUM_CORES miners and round-robins their solutions out.
// Optional watchdog enabled by defining MINER_SCHED_TIMEOUT_EN.
module miner_job_scheduler #(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned SLICE_LOG2     = 32,
  parameter bit          STOP_ON_FIRST  = 1'b1,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000000
) (
  input  logic                  clk,
  input  logic                  rst,
  miner_job_scheduler_if.master bus_io
);

  localparam int unsigned IdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {StIdle, StDispatch, StRun, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [63:0]             base_q, base_d;
  logic [64*NUM_CORES-1:0] start_q, start_d;
  logic [NUM_CORES-1:0]    core_run_q, core_run_d;
  logic                    soln_valid_q, soln_valid_d;
  logic [63:0]             soln_nonce_q, soln_nonce_d;
  logic [3:0]              soln_core_q, soln_core_d;
  logic                    irq_q, irq_d;
  logic [IdxW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0]    core_ack;
  logic                    grant_vld;
  logic [IdxW-1:0]         grant_idx;
  logic [IdxW-1:0]         scan_idx;
  logic                    slot_free;
  logic                    job_accept;
  logic                    timeout_hit;

  assign job_accept = (state_q == StIdle) && bus_io.job_valid;
  assign slot_free  = !soln_valid_q || bus_io.soln_ready;

  // First requesting core at or after rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (state_q == StRun && slot_free) begin
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
        scan_idx = IdxW'((32'(rr_ptr_q) + k) % NUM_CORES);
        if (!grant_vld && bus_io.core_found[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    start_d      = start_q;
    core_run_d   = core_run_q;
    soln_valid_d = soln_valid_q;
    soln_nonce_d = soln_nonce_q;
    soln_core_d  = soln_core_q;
    irq_d        = irq_q;
    rr_ptr_d     = rr_ptr_q;
    core_ack     = '0;

    if (grant_vld) begin
      core_ack[grant_idx] = 1'b1;
      soln_valid_d        = 1'b1;
      soln_nonce_d        = bus_io.core_solution[64*32'(grant_idx) +: 64];
      soln_core_d         = 4'(grant_idx);
      irq_d               = 1'b1;
      rr_ptr_d            = IdxW'((32'(grant_idx) + 32'd1) % NUM_CORES);
    end else begin
      if (soln_valid_q && bus_io.soln_ready) soln_valid_d = 1'b0;
      if (bus_io.irq_clr) irq_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (bus_io.job_valid) begin
          base_d  = bus_io.job_start_nonce;
          state_d = StDispatch;
        end
      end
      StDispatch: begin
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
          start_d[64*k +: 64] = base_q + (64'(k) << SLICE_LOG2);
        end
        core_run_d = '1;
        state_d    = StRun;
      end
      StRun: begin
        // A grant in the exit cycle is still captured above.
        if (bus_io.stop || (STOP_ON_FIRST && grant_vld) || timeout_hit) begin
          core_run_d = '0;
          state_d    = StDrain;
        end
      end
      StDrain: begin
        core_run_d = '0;
        if (!soln_valid_q || bus_io.soln_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      base_q       <= '0;
      start_q      <= '0;
      core_run_q   <= '0;
      soln_valid_q <= 1'b0;
      soln_nonce_q <= '0;
      soln_core_q  <= '0;
      irq_q        <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      start_q      <= start_d;
      core_run_q   <= core_run_d;
      soln_valid_q <= soln_valid_d;
      soln_nonce_q <= soln_nonce_d;
      soln_core_q  <= soln_core_d;
      irq_q        <= irq_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

`ifdef MINER_SCHED_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        timed_out_q, timed_out_d;

  assign timeout_hit = (state_q == StRun) && (cnt_q == TIMEOUT_CYCLES - 32'd1);

  always_comb begin
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
    if (state_q == StDispatch) cnt_d = '0;
    else if (state_q == StRun) cnt_d = cnt_q + 32'd1;
    if (job_accept) timed_out_d = 1'b0;
    else if (timeout_hit) timed_out_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign bus_io.timed_out = timed_out_q;
`else
  logic unused_timeout;
  assign unused_timeout   = ^TIMEOUT_CYCLES ^ job_accept;
  assign timeout_hit      = 1'b0;
  assign bus_io.timed_out = 1'b0;
`endif

  assign bus_io.job_ready        = (state_q == StIdle);
  assign bus_io.busy             = (state_q != StIdle);
  assign bus_io.core_run         = core_run_q;
  assign bus_io.core_start_nonce = start_q;
  assign bus_io.core_ack         = core_ack;
  assign bus_io.soln_valid       = soln_valid_q;
  assign bus_io.soln_nonce       = soln_nonce_q;
  assign bus_io.soln_core        = soln_core_q;
  assign bus_io.irq              = irq_q;

endmodule

// File: tb/tb_miner_job_scheduler.sv
// Scoreboard bench: stimulus pushes expected solutions, a negedge monitor pops on handshake.
// Two instances cover STOP_ON_FIRST=0 (u_dut0) and STOP_ON_FIRST=1 (u_dut1).
module tb_miner_job_scheduler;

  typedef struct packed {
    logic [3:0]  core;
    logic [63:0] nonce;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   ack_cnt0 = 0;
  int   ack_cnt1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  miner_job_scheduler_if #(.NUM_CORES(4)) b0 ();
  miner_job_scheduler_if #(.NUM_CORES(4)) b1 ();

  miner_job_scheduler #(
    .NUM_CORES(4), .SLICE_LOG2(32), .STOP_ON_FIRST(1'b0), .TIMEOUT_CYCLES(32'd100)
  ) u_dut0 (
    .clk(clk), .rst(rst), .bus_io(b0)
  );

  miner_job_scheduler #(
    .NUM_CORES(4), .SLICE_LOG2(32), .STOP_ON_FIRST(1'b1), .TIMEOUT_CYCLES(32'd100)
  ) u_dut1 (
    .clk(clk), .rst(rst), .bus_io(b1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sol(input int i);
    return 64'hC0DE_0000_0000_0000 + 64'(i);
  endfunction

  // Cores drop core_found on the edge that sees their ack.
  task automatic tick();
    logic [3:0] a0, a1;
    @(negedge clk);
    a0 = b0.core_ack;
    a1 = b1.core_ack;
    @(posedge clk);
    #1;
    ack_cnt0 += $countones(a0);
    ack_cnt1 += $countones(a1);
    b0.core_found = b0.core_found & ~a0;
    b1.core_found = b1.core_found & ~a1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b0.soln_valid && b0.soln_ready) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb0_unexpected: got core %0d nonce %h want none", b0.soln_core,
                 b0.soln_nonce);
      end else begin
        e = q0.pop_front();
        chk("sb0_core", 64'(b0.soln_core), 64'(e.core));
        chk("sb0_nonce", b0.soln_nonce, e.nonce);
      end
    end
    if (!rst && b1.soln_valid && b1.soln_ready) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb1_unexpected: got core %0d nonce %h want none", b1.soln_core,
                 b1.soln_nonce);
      end else begin
        e = q1.pop_front();
        chk("sb1_core", 64'(b1.soln_core), 64'(e.core));
        chk("sb1_nonce", b1.soln_nonce, e.nonce);
      end
    end
  end

  initial begin
    b0.job_valid = 0; b0.job_start_nonce = '0; b0.stop = 0; b0.core_found = '0;
    b0.soln_ready = 0; b0.irq_clr = 0;
    b1.job_valid = 0; b1.job_start_nonce = '0; b1.stop = 0; b1.core_found = '0;
    b1.soln_ready = 0; b1.irq_clr = 0;
    for (int i = 0; i < 4; i++) begin
      b0.core_solution[64*i +: 64] = sol(i);
      b1.core_solution[64*i +: 64] = sol(i + 16);
    end
    b1.core_solution[64 +: 64] = 64'h1234;

    repeat (2) tick();
    rst = 0;
    tick();
    chk("rst_job_ready", 64'(b0.job_ready), 64'd1);
    chk("rst_busy", 64'(b0.busy), 64'd0);
    chk("rst_core_run", 64'(b0.core_run), 64'd0);
    chk("rst_soln_valid", 64'(b0.soln_valid), 64'd0);
    chk("rst_irq", 64'(b0.irq), 64'd0);
    chk("rst_timed_out", 64'(b0.timed_out), 64'd0);
    chk("rst_start0", b0.core_start_nonce[63:0], 64'd0);
    chk("rst1_job_ready", 64'(b1.job_ready), 64'd1);

    // Dispatch with carry into the upper word.
    b0.job_valid = 1;
    b0.job_start_nonce = 64'hFFFF_FFFF_0000_0010;
    tick();
    b0.job_valid = 0;
    chk("disp_busy", 64'(b0.busy), 64'd1);
    chk("disp_job_ready", 64'(b0.job_ready), 64'd0);
    chk("disp_run_early", 64'(b0.core_run), 64'd0);
    tick();
    chk("disp_core_run", 64'(b0.core_run), 64'hF);
    chk("disp_start0", b0.core_start_nonce[0 +: 64], 64'hFFFF_FFFF_0000_0010);
    chk("disp_start1", b0.core_start_nonce[64 +: 64], 64'h0000_0000_0000_0010);
    chk("disp_start2", b0.core_start_nonce[128 +: 64], 64'h0000_0001_0000_0010);
    chk("disp_start3", b0.core_start_nonce[192 +: 64], 64'h0000_0002_0000_0010);

    // Round robin 0,1,3 with an always-ready consumer.
    b0.soln_ready = 1;
    b0.core_found = 4'b1011;
    q0.push_back('{4'd0, sol(0)});
    q0.push_back('{4'd1, sol(1)});
    q0.push_back('{4'd3, sol(3)});
    tick();
    chk("rr_latency_valid", 64'(b0.soln_valid), 64'd1);
    chk("rr_first_core", 64'(b0.soln_core), 64'd0);
    repeat (3) tick();
    chk("rr_ack_count", 64'(ack_cnt0), 64'd3);
    chk("rr_valid_clear", 64'(b0.soln_valid), 64'd0);
    chk("rr_irq", 64'(b0.irq), 64'd1);
    b0.irq_clr = 1;
    tick();
    b0.irq_clr = 0;
    chk("irq_clr", 64'(b0.irq), 64'd0);

    // rr_ptr wrapped to 0: core 1 must win before core 3.
    b0.core_found = 4'b1010;
    q0.push_back('{4'd1, sol(1)});
    q0.push_back('{4'd3, sol(3)});
    repeat (3) tick();
    chk("rr_wrap_acks", 64'(ack_cnt0), 64'd5);

    // Backpressure: core 3 waits until the slot frees, then is granted that cycle.
    b0.soln_ready = 0;
    b0.core_found = 4'b1100;
    q0.push_back('{4'd2, sol(2)});
    q0.push_back('{4'd3, sol(3)});
    repeat (3) tick();
    chk("bp_hold_acks", 64'(ack_cnt0), 64'd6);
    chk("bp_hold_core", 64'(b0.soln_core), 64'd2);
    chk("bp_hold_found", 64'(b0.core_found), 64'b1000);
    b0.soln_ready = 1;
    tick();
    chk("bp_same_cycle_acks", 64'(ack_cnt0), 64'd7);
    chk("bp_next_valid", 64'(b0.soln_valid), 64'd1);
    chk("bp_next_core", 64'(b0.soln_core), 64'd3);
    tick();

    // irq_clr colliding with a new grant keeps irq set.
    b0.irq_clr = 1;
    b0.core_found = 4'b0001;
    q0.push_back('{4'd0, sol(0)});
    tick();
    b0.irq_clr = 0;
    chk("irqclr_grant_irq", 64'(b0.irq), 64'd1);
    chk("irqclr_grant_core", 64'(b0.soln_core), 64'd0);
    tick();

    // stop with a grant in the same cycle: capture then drain.
    b0.stop = 1;
    b0.core_found = 4'b0100;
    q0.push_back('{4'd2, sol(2)});
    tick();
    b0.stop = 0;
    chk("stopg_core_run", 64'(b0.core_run), 64'd0);
    chk("stopg_valid", 64'(b0.soln_valid), 64'd1);
    chk("stopg_core", 64'(b0.soln_core), 64'd2);
    chk("stopg_busy", 64'(b0.busy), 64'd1);
    tick();
    chk("stopg_idle", 64'(b0.job_ready), 64'd1);
    chk("stopg_valid_clr", 64'(b0.soln_valid), 64'd0);

    // Stop-on-first on u_dut1.
    b1.job_valid = 1;
    b1.job_start_nonce = 64'd0;
    tick();
    b1.job_valid = 0;
    tick();
    chk("sof_core_run", 64'(b1.core_run), 64'hF);
    b1.core_found = 4'b0010;
    q1.push_back('{4'd1, 64'h1234});
    tick();
    chk("sof_nonce", b1.soln_nonce, 64'h1234);
    chk("sof_core", 64'(b1.soln_core), 64'd1);
    chk("sof_irq", 64'(b1.irq), 64'd1);
    chk("sof_core_run_off", 64'(b1.core_run), 64'd0);
    b1.core_found = 4'b0001;
    b1.job_valid = 1;
    tick();
    chk("sof_drain_no_ack", 64'(ack_cnt1), 64'd1);
    chk("sof_drain_busy", 64'(b1.busy), 64'd1);
    chk("sof_drain_job_ready", 64'(b1.job_ready), 64'd0);
    b1.job_valid = 0;
    b1.core_found = 4'b0000;
    b1.soln_ready = 1;
    tick();
    chk("sof_idle", 64'(b1.job_ready), 64'd1);
    chk("sof_valid_clr", 64'(b1.soln_valid), 64'd0);
    chk("sof_irq_sticky", 64'(b1.irq), 64'd1);
    b1.irq_clr = 1;
    tick();
    b1.irq_clr = 0;
    chk("sof_irq_clr", 64'(b1.irq), 64'd0);

    // Reset mid-job discards a held solution.
    b0.soln_ready = 0;
    b0.job_valid = 1;
    tick();
    b0.job_valid = 0;
    tick();
    b0.core_found = 4'b0001;
    tick();
    chk("mid_held_valid", 64'(b0.soln_valid), 64'd1);
    rst = 1;
    tick();
    chk("mid_rst_core_run", 64'(b0.core_run), 64'd0);
    chk("mid_rst_valid", 64'(b0.soln_valid), 64'd0);
    chk("mid_rst_job_ready", 64'(b0.job_ready), 64'd1);
    chk("mid_rst_irq", 64'(b0.irq), 64'd0);
    rst = 0;
    b0.core_found = 4'b0000;
    tick();

`ifdef MINER_SCHED_TIMEOUT_EN
    b0.job_valid = 1;
    tick();
    b0.job_valid = 0;
    tick();
    repeat (99) tick();
    chk("to_not_yet", 64'(b0.timed_out), 64'd0);
    chk("to_still_run", 64'(b0.core_run), 64'hF);
    tick();
    chk("to_flag", 64'(b0.timed_out), 64'd1);
    chk("to_drain_run", 64'(b0.core_run), 64'd0);
    chk("to_drain_busy", 64'(b0.busy), 64'd1);
    tick();
    chk("to_idle", 64'(b0.job_ready), 64'd1);
    chk("to_sticky", 64'(b0.timed_out), 64'd1);
    b0.job_valid = 1;
    tick();
    b0.job_valid = 0;
    chk("to_clear_on_job", 64'(b0.timed_out), 64'd0);
    b0.stop = 1;
    repeat (3) tick();
    b0.stop = 0;
    chk("to_stop_idle", 64'(b0.job_ready), 64'd1);
`endif

    chk("sb_empty", 64'(q0.size() + q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
